// File: rtl/fwd_hazard_if.sv
// Forwarding/hazard unit bus.
// master: pipeline control side; drives the decoded register fields and flush,
//         receives the operand bypass selects and stall/bubble control.
// slave : fwd_hazard_unit.
interface fwd_hazard_if #(
  parameter int AW    = 3,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);
  logic [NSRC*AW-1:0] idex_src;
  logic [NSRC*AW-1:0] ifid_src;
  logic [NSRC-1:0]    ifid_src_used;
  logic               idex_memread;
  logic               idex_regwrite;
  logic [AW-1:0]      idex_rd;
  logic               exmem_regwrite;
  logic               exmem_memread;
  logic [AW-1:0]      exmem_rd;
  logic               memwb_regwrite;
  logic [AW-1:0]      memwb_rd;
  logic               flush;
  logic [2*NSRC-1:0]  fwd_sel;
  logic               wbh_load;
  logic               stall;
  logic               bubble;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output idex_src, ifid_src, ifid_src_used, idex_memread, idex_regwrite, idex_rd,
           exmem_regwrite, exmem_memread, exmem_rd, memwb_regwrite, memwb_rd, flush,
    input  fwd_sel, wbh_load, stall, bubble, stall_cycles
  );

  modport slave (
    input  idex_src, ifid_src, ifid_src_used, idex_memread, idex_regwrite, idex_rd,
           exmem_regwrite, exmem_memread, exmem_rd, memwb_regwrite, memwb_rd, flush,
    output fwd_sel, wbh_load, stall, bubble, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Per-operand bypass selects for the EX instruction (EX/MEM > MEM/WB > WB
// history > register file), a load-use stall FSM inserting LOAD_LAT stall
// cycles per hazard, and a saturating stall-cycle counter.
// Ports: clk, rst (sync, active high), bus (fwd_hazard_if.slave):
//   inputs  idex_*/ifid_*/exmem_*/memwb_* register fields, flush
//   outputs fwd_sel[2i+:2], wbh_load, stall, bubble, stall_cycles

// One operand lane: bypass select for the EX source and the load-use match
// for the ID source.
module fwd_hazard_lane #(
  parameter int AW        = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic [AW-1:0] idex_src,
  input  logic [AW-1:0] ifid_src,
  input  logic          ifid_used,
  input  logic          exmem_en,
  input  logic [AW-1:0] exmem_rd,
  input  logic          memwb_en,
  input  logic [AW-1:0] memwb_rd,
  input  logic          wbh_valid,
  input  logic [AW-1:0] wbh_rd,
  input  logic [AW-1:0] idex_rd,
  output logic [1:0]    sel,
  output logic          ld_match
);
  always_comb begin
    sel = 2'b00;
    if (exmem_en && exmem_rd == idex_src)                       sel = 2'b10;
    else if (memwb_en && memwb_rd == idex_src)                  sel = 2'b01;
    else if ((WB_BYPASS != 0) && wbh_valid && wbh_rd == idex_src) sel = 2'b11;
  end

  assign ld_match = ifid_used && (ifid_src == idex_rd);
endmodule

module fwd_hazard_unit #(
  parameter int AW        = 3,
  parameter int NSRC      = 2,
  parameter int LOAD_LAT  = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);
  typedef enum logic {S_RUN, S_STALL} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t                    state, state_nx;
  logic [2:0]                cnt, cnt_nx;
  logic                      wbh_valid;
  logic [AW-1:0]             wbh_rd;
  logic [CNT_W-1:0]          stall_cnt;
  logic                      stall_c, haz, wbh_set;
  logic                      exmem_en, memwb_en;
  logic [NSRC-1:0][AW-1:0]   idex_src_v, ifid_src_v;
  logic [NSRC-1:0][1:0]      sel_v;
  logic [NSRC-1:0]           ld_match;

  assign idex_src_v = bus.idex_src;
  assign ifid_src_v = bus.ifid_src;

  // r0 is hard-wired: a zero destination never qualifies a producer. A load
  // in MEM has no data yet, so it never feeds the EX/MEM path.
  assign exmem_en = bus.exmem_regwrite && !bus.exmem_memread && (bus.exmem_rd != '0);
  assign memwb_en = bus.memwb_regwrite && (bus.memwb_rd != '0);
  assign wbh_set  = memwb_en;

  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : g_lane
      fwd_hazard_lane #(.AW(AW), .WB_BYPASS(WB_BYPASS)) u_lane (
        .idex_src (idex_src_v[i]),
        .ifid_src (ifid_src_v[i]),
        .ifid_used(bus.ifid_src_used[i]),
        .exmem_en (exmem_en),
        .exmem_rd (bus.exmem_rd),
        .memwb_en (memwb_en),
        .memwb_rd (bus.memwb_rd),
        .wbh_valid(wbh_valid),
        .wbh_rd   (wbh_rd),
        .idex_rd  (bus.idex_rd),
        .sel      (sel_v[i]),
        .ld_match (ld_match[i])
      );
    end
  endgenerate

  assign haz = bus.idex_memread && bus.idex_regwrite && (bus.idex_rd != '0) && (|ld_match);

  // WB history: remembers last cycle's write-back so a read-before-write
  // register file still sees the value for one more cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbh_valid <= 1'b0;
      wbh_rd    <= '0;
    end else begin
      wbh_valid <= wbh_set;
      if (wbh_set) wbh_rd <= bus.memwb_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // RUN covers the first stall cycle of a hazard; STALL counts the remaining
  // LOAD_LAT-1 cycles. Flush overrides everything and drops back to RUN.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_c  = 1'b0;
    if (rst) begin
      stall_c = 1'b0;
    end else if (bus.flush) begin
      state_nx = S_RUN;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (haz) begin
            stall_c = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nx = S_STALL;
              cnt_nx   = LAT_M1;
            end
          end
        end
        S_STALL: begin
          stall_c = 1'b1;
          cnt_nx  = cnt - 3'd1;
          if (cnt == 3'd1) state_nx = S_RUN;
        end
        default: begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                           stall_cnt <= '0;
    else if (stall_c && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.fwd_sel      = rst ? '0 : sel_v;
  assign bus.wbh_load     = wbh_set && !rst;
  assign bus.stall        = stall_c;
  assign bus.bubble       = stall_c;
  assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances share one stimulus stream.
//   u_a: LOAD_LAT=1, WB_BYPASS=1, CNT_W=16
//   u_b: LOAD_LAT=3, WB_BYPASS=0, CNT_W=4
// Expected outputs come from a behavioural model, are queued when the stimulus
// is applied and compared against the outputs at the following falling edge.
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [5:0] idex_src;
    logic [5:0] ifid_src;
    logic [1:0] used;
    logic       idex_memread;
    logic       idex_regwrite;
    logic [2:0] idex_rd;
    logic       exmem_regwrite;
    logic       exmem_memread;
    logic [2:0] exmem_rd;
    logic       memwb_regwrite;
    logic [2:0] memwb_rd;
  } stim_t;

  typedef struct packed {
    logic [3:0]  fwd;
    logic        stall;
    logic        bubble;
    logic        load;
    logic [15:0] cnt;
  } exp_t;

  logic  clk = 1'b0;
  stim_t st  = '0;
  stim_t nx  = '0;
  logic  rst;

  int checks = 0;
  int fails  = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // behavioural model state, index 0 = u_a, 1 = u_b
  int         lat  [2] = '{1, 3};
  int         wbb  [2] = '{1, 0};
  int         cmax [2] = '{65535, 15};
  int         rem  [2] = '{0, 0};
  logic       wv   [2] = '{1'b0, 1'b0};
  logic [2:0] wr   [2] = '{3'd0, 3'd0};
  int         sc   [2] = '{0, 0};

  always #5 clk = ~clk;

  fwd_hazard_if #(.AW(3), .NSRC(2), .CNT_W(16)) bus_a ();
  fwd_hazard_if #(.AW(3), .NSRC(2), .CNT_W(4))  bus_b ();

  assign rst = st.rst;
  assign bus_a.idex_src = st.idex_src;        assign bus_b.idex_src = st.idex_src;
  assign bus_a.ifid_src = st.ifid_src;        assign bus_b.ifid_src = st.ifid_src;
  assign bus_a.ifid_src_used = st.used;       assign bus_b.ifid_src_used = st.used;
  assign bus_a.idex_memread = st.idex_memread;   assign bus_b.idex_memread = st.idex_memread;
  assign bus_a.idex_regwrite = st.idex_regwrite; assign bus_b.idex_regwrite = st.idex_regwrite;
  assign bus_a.idex_rd = st.idex_rd;          assign bus_b.idex_rd = st.idex_rd;
  assign bus_a.exmem_regwrite = st.exmem_regwrite; assign bus_b.exmem_regwrite = st.exmem_regwrite;
  assign bus_a.exmem_memread = st.exmem_memread;   assign bus_b.exmem_memread = st.exmem_memread;
  assign bus_a.exmem_rd = st.exmem_rd;        assign bus_b.exmem_rd = st.exmem_rd;
  assign bus_a.memwb_regwrite = st.memwb_regwrite; assign bus_b.memwb_regwrite = st.memwb_regwrite;
  assign bus_a.memwb_rd = st.memwb_rd;        assign bus_b.memwb_rd = st.memwb_rd;
  assign bus_a.flush = st.flush;              assign bus_b.flush = st.flush;

  fwd_hazard_unit #(.AW(3), .NSRC(2), .LOAD_LAT(1), .WB_BYPASS(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  fwd_hazard_unit #(.AW(3), .NSRC(2), .LOAD_LAT(3), .WB_BYPASS(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for the applied stimulus, then advance model state as
  // of the next rising edge.
  task automatic model_step(input int k, output exp_t e);
    logic [2:0] s [2];
    logic       haz, hit1, hit0, ld;
    logic [1:0] sel;
    s[0] = st.idex_src[2:0];
    s[1] = st.idex_src[5:3];
    hit0 = st.used[0] && st.ifid_src[2:0] == st.idex_rd;
    hit1 = st.used[1] && st.ifid_src[5:3] == st.idex_rd;
    haz  = st.idex_memread && st.idex_regwrite && st.idex_rd != 0 && (hit0 || hit1);
    ld   = st.memwb_regwrite && st.memwb_rd != 0;
    e = '0;
    e.cnt = 16'(sc[k]);
    if (!st.rst) begin
      for (int i = 0; i < 2; i++) begin
        // lowest priority first, younger producers overwrite
        sel = 2'b00;
        if (wbb[k] != 0 && wv[k] && wr[k] == s[i]) sel = 2'b11;
        if (ld && st.memwb_rd == s[i]) sel = 2'b01;
        if (st.exmem_regwrite && !st.exmem_memread && st.exmem_rd != 0 && st.exmem_rd == s[i])
          sel = 2'b10;
        e.fwd[2*i +: 2] = sel;
      end
      e.stall  = !st.flush && (rem[k] > 0 || haz);
      e.bubble = e.stall;
      e.load   = ld;
    end
    if (st.rst) begin
      rem[k] = 0; wv[k] = 1'b0; wr[k] = 3'd0; sc[k] = 0;
    end else begin
      if (e.stall && sc[k] < cmax[k]) sc[k] = sc[k] + 1;
      wv[k] = ld;
      if (ld) wr[k] = st.memwb_rd;
      if (st.flush)      rem[k] = 0;
      else if (rem[k] > 0) rem[k] = rem[k] - 1;
      else if (haz)      rem[k] = lat[k] - 1;
    end
  endtask

  task automatic step();
    exp_t ea, eb;
    @(posedge clk);
    #1;
    st = nx;
    model_step(0, ea);
    model_step(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nx = '0;
      step();
    end
  endtask

  task automatic load_use(input logic [1:0] used, input logic [2:0] rd, input logic fl);
    nx = '0;
    nx.idex_memread = 1'b1; nx.idex_regwrite = 1'b1; nx.idex_rd = rd;
    nx.ifid_src = {3'd2, 3'd2}; nx.used = used; nx.flush = fl;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("a_fwd_sel", 32'(bus_a.fwd_sel), 32'(e.fwd));
      chk("a_stall", 32'(bus_a.stall), 32'(e.stall));
      chk("a_bubble", 32'(bus_a.bubble), 32'(e.bubble));
      chk("a_wbh_load", 32'(bus_a.wbh_load), 32'(e.load));
      chk("a_stall_cycles", 32'(bus_a.stall_cycles), 32'(e.cnt));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("b_fwd_sel", 32'(bus_b.fwd_sel), 32'(e.fwd));
      chk("b_stall", 32'(bus_b.stall), 32'(e.stall));
      chk("b_bubble", 32'(bus_b.bubble), 32'(e.bubble));
      chk("b_wbh_load", 32'(bus_b.wbh_load), 32'(e.load));
      chk("b_stall_cycles", 32'(bus_b.stall_cycles), 32'(e.cnt[3:0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    st = '0; st.rst = 1'b1;
    // reset with live-looking inputs: every output must stay quiet
    nx = '0; nx.rst = 1'b1;
    nx.exmem_regwrite = 1'b1; nx.exmem_rd = 3'd3; nx.idex_src = {3'd3, 3'd4};
    nx.memwb_regwrite = 1'b1; nx.memwb_rd = 3'd4;
    nx.idex_memread = 1'b1; nx.idex_regwrite = 1'b1; nx.idex_rd = 3'd2;
    nx.ifid_src = {3'd2, 3'd2}; nx.used = 2'b11;
    step(); step();
    // history must be empty after reset
    nx = '0; nx.idex_src = {3'd4, 3'd4};
    step();

    // EX/MEM beats MEM/WB on the same register
    nx = '0; nx.idex_src = {3'd3, 3'd3};
    nx.exmem_regwrite = 1'b1; nx.exmem_rd = 3'd3;
    nx.memwb_regwrite = 1'b1; nx.memwb_rd = 3'd3;
    step();
    nx.exmem_regwrite = 1'b0;
    step();
    // load in MEM cannot forward, MEM/WB wins
    nx.exmem_regwrite = 1'b1; nx.exmem_memread = 1'b1;
    step();
    // mixed operands: op1 from EX/MEM, op0 from MEM/WB
    nx = '0; nx.idex_src = {3'd6, 3'd1};
    nx.exmem_regwrite = 1'b1; nx.exmem_rd = 3'd6;
    nx.memwb_regwrite = 1'b1; nx.memwb_rd = 3'd1;
    step();

    // WB history window: write r5, then read it one and two cycles later
    nx = '0; nx.memwb_regwrite = 1'b1; nx.memwb_rd = 3'd5;
    step();
    nx = '0; nx.idex_src = {3'd0, 3'd5};
    step();
    step();

    // r0 never forwards
    nx = '0; nx.idex_src = 6'd0;
    nx.exmem_regwrite = 1'b1; nx.memwb_regwrite = 1'b1;
    step();
    nx = '0;
    step();

    // load-use hazards
    load_use(2'b01, 3'd2, 1'b0);
    idle(4);
    load_use(2'b00, 3'd2, 1'b0);      // operand not read
    load_use(2'b10, 3'd2, 1'b0);      // operand 1 used, matches
    idle(4);
    nx = '0; nx.idex_memread = 1'b1; nx.idex_regwrite = 1'b1; nx.idex_rd = 3'd0;
    nx.used = 2'b11;                  // ifid_src = r0, load to r0
    step();
    idle(1);

    // flush in the second stall cycle, and flush coinciding with the hazard
    load_use(2'b01, 3'd2, 1'b0);
    nx = '0; nx.flush = 1'b1;
    step();
    idle(3);
    load_use(2'b01, 3'd2, 1'b1);
    idle(2);

    // saturate the 4-bit counter on u_b
    for (int n = 0; n < 6; n++) begin
      load_use(2'b01, 3'd2, 1'b0);
      idle(3);
    end

    // reset in the middle of a stall
    load_use(2'b01, 3'd2, 1'b0);
    nx = '0; nx.rst = 1'b1; nx.memwb_regwrite = 1'b1; nx.memwb_rd = 3'd7;
    step();
    nx = '0; nx.idex_src = {3'd7, 3'd7};
    step();
    idle(2);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      nx = '0;
      nx.rst            = ($urandom_range(0, 63) == 0);
      nx.flush          = ($urandom_range(0, 7) == 0);
      nx.idex_src       = 6'($urandom_range(0, 63));
      nx.ifid_src       = 6'($urandom_range(0, 63));
      nx.used           = 2'($urandom_range(0, 3));
      nx.idex_memread   = 1'($urandom_range(0, 1));
      nx.idex_regwrite  = ($urandom_range(0, 3) != 0);
      nx.idex_rd        = 3'($urandom_range(0, 7));
      nx.exmem_regwrite = 1'($urandom_range(0, 1));
      nx.exmem_memread  = ($urandom_range(0, 3) == 0);
      nx.exmem_rd       = 3'($urandom_range(0, 7));
      nx.memwb_regwrite = 1'($urandom_range(0, 1));
      nx.memwb_rd       = 3'($urandom_range(0, 7));
      step();
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
